// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out transmitter with busy/done framing
// Emits one bit of a captured word per enabled clock on a complementary Q/not_Q pair.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             not_Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  output logic             Q,
  output logic             not_Q,
  output logic             Ready,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             q_r;

  logic [WIDTH-1:0] sreg_next;
  logic             bit_next;
  logic             bit_first;

  // The bit leaving next is already on Q, so the one after it sits one slot inward.
  always_comb begin
    sreg_next = sreg;
    bit_next  = 1'b0;
    bit_first = 1'b0;
    if (MSB_FIRST) begin
      sreg_next = sreg << 1;
      bit_next  = sreg[WIDTH-2];
      bit_first = D[WIDTH-1];
    end else begin
      sreg_next = sreg >> 1;
      bit_next  = sreg[1];
      bit_first = D[0];
    end
  end

  always_ff @(posedge Clk or negedge not_Rst) begin
    if (!not_Rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      q_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          q_r <= 1'b0;
          if (Load) begin
            sreg  <= D;
            q_r   <= bit_first;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (En) begin
            if (cnt == LAST) begin
              q_r   <= 1'b0;
              state <= ST_DONE;
            end else begin
              sreg <= sreg_next;
              q_r  <= bit_next;
              cnt  <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          q_r   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          q_r   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Q     = q_r;
  assign not_Q = ~q_r;
  assign Ready = (state == ST_IDLE);
  assign Busy  = (state == ST_SHIFT);
  assign Done  = (state == ST_DONE);

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out transmitter: the write-side counterpart to the latch/flip-flop storage elements.
- Captures a WIDTH-bit word on a load request, then drives it one bit per enabled clock on a complementary Q/not_Q pair.
- Frames each word with a busy/done handshake.
- Feeds serial receivers and shift-register chains built from the same library of simple storage elements.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 0, bit order: 0 = D[0] first, 1 = D[WIDTH-1] first.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- not_Rst  input  1  asynchronous, active-low reset.
- Load  input  1  load request; honoured only when Ready=1.
- D  input  WIDTH  parallel word, sampled on the accepting edge.
- En  input  1  shift enable; 0 stalls the transmitter while in SHIFT.
- Q  output  1  serial data, registered.
- not_Q  output  1  complement of Q, always ~Q, combinational.
- Ready  output  1  high in IDLE; transmitter can accept Load.
- Busy  output  1  high in SHIFT.
- Done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (not_Rst=0, any time, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - Q=0, not_Q=1, Ready=1, Busy=0, Done=0.
  - Release is synchronous to the next Clk edge.
  - Reset mid-word aborts the word; no Done pulse is issued.
- States: IDLE, SHIFT, DONE. Ready, Busy and Done are decoded from the state register only.
- IDLE:
  - Q holds idle level 0.
  - Edge with Load=1: capture D into the shift register, Q<=first bit (per MSB_FIRST), counter<=0, go to SHIFT.
  - Load=0: stay in IDLE.
- SHIFT:
  - En=1 at an edge, counter<WIDTH-1: shift the register one position, Q<=next bit, counter+1.
  - En=1 at an edge, counter=WIDTH-1: go to DONE, Q<=0.
  - En=0: all state, Q and the counter hold; a stall has no length limit.
  - Load is ignored; D changes have no effect.
- DONE:
  - Done=1 for exactly one cycle, Q=0.
  - Next edge goes to IDLE unconditionally.
  - Load asserted during DONE is ignored and is not queued.
- Timing with En held 1 and load accepted at edge k:
  - Bit j is on Q between edges k+j and k+j+1, for j=0..WIDTH-1.
  - DONE is entered at edge k+WIDTH; IDLE at edge k+WIDTH+1.
  - Minimum load-to-load spacing is WIDTH+2 cycles.
- Counter width: clog2(WIDTH), wraps only through a reload; never counts past WIDTH-1.
- Shift direction:
  - MSB_FIRST=0: right shift, emit LSB.
  - MSB_FIRST=1: left shift, emit MSB.
  - Vacated positions fill with 0.
- Invariant: not_Q==~Q in every cycle, including during reset.
- Invariant: exactly one of Ready/Busy/Done is high, except that Ready and Done are both low only in SHIFT.

Test Plan:
- Reset then idle: not_Rst low 3 cycles, release, Load=0 for 5 cycles -> Q=0, not_Q=1, Ready=1, Busy=0, Done=0 throughout.
- Basic LSB-first, WIDTH=8, D=8'hA5, En=1 -> Q sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after load; Done=1 on cycle 9; Ready=1 on cycle 10; not_Q complementary on every cycle.
- MSB_FIRST=1, D=8'h81 -> Q sequence 1,0,0,0,0,0,0,1; Done pulse width exactly 1 cycle.
- Stall: D=8'h0F, En dropped for 4 cycles after the 3rd bit -> Q holds 1 for the 4 stalled cycles; the remaining bits 1,0,0,0,0 follow once En returns; total SHIFT time 12 cycles.
- Load while busy: second Load with D=8'hFF during SHIFT and again during DONE -> both ignored; the first word completes unchanged and Ready returns only after DONE.
- Reset mid-word: assert not_Rst after the 4th bit of 8'h3C -> Q=0, not_Q=1, Ready=1 immediately (before the next Clk edge); no Done pulse; a fresh Load of 8'h55 afterwards transmits correctly.
